sparc_windowed_register_file: RTL and testbench

Windowed general-purpose register file for the SPARC8 datapath, sitting directly upstream of the ALU and the source-operand-2 handler. It provides two combinational read ports: port A feeds ALU operand A, and port B feeds the handler's register input. It also provides one synchronous write port for results. It implements SPARC register windows: globals, overlapping in/out windows, a current window pointer (CWP), a window invalid mask (WIM), and SAVE/RESTORE with overflow/underflow detection.

---
 rtl/sparc_windowed_register_file.sv | 68 ++++++
 tb/tb_sparc_windowed_register_file.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sparc_windowed_register_file.sv
// sparc_windowed_register_file: SPARC register file with overlapping windows, CWP/WIM and SAVE/RESTORE traps
module sparc_windowed_register_file #(
    parameter int NWINDOWS = 4,
    parameter int CWPW     = $clog2(NWINDOWS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          ra_addr,
    input  logic [4:0]          rb_addr,
    output logic [31:0]         pa,
    output logic [31:0]         pb,
    input  logic [4:0]          rc_addr,
    input  logic [31:0]         rc_data,
    input  logic                rc_we,
    input  logic                save,
    input  logic                restore,
    input  logic                wim_we,
    input  logic [NWINDOWS-1:0] wim_d,
    output logic [CWPW-1:0]     cwp,
    output logic [NWINDOWS-1:0] wim,
    output logic                win_ovf,
    output logic                win_unf
);
    localparam int NREG = 8 + 16 * NWINDOWS;
    localparam int PW   = $clog2(NREG);

    logic [31:0]     regs [NREG];
    logic [CWPW-1:0] cwp_m1, cwp_p1, cwp_nx;
    logic            sv_req, rs_req, sv_rej, rs_rej, wr_ok;

    // ins of window w live in the outs block of window w+1, giving the overlap
    function automatic logic [PW-1:0] phys(input logic [4:0] a, input logic [CWPW-1:0] w);
        logic [CWPW-1:0] win;
        win = (a[4:3] == 2'b11) ? w + CWPW'(1) : w;
        return (a[4:3] == 2'b00) ? PW'(a) :
               PW'(8 + 16 * int'(win) + int'(a[2:0]) + ((a[4:3] == 2'b10) ? 8 : 0));
    endfunction

    always_comb begin
        cwp_m1 = cwp - CWPW'(1);
        cwp_p1 = cwp + CWPW'(1);
        sv_req = save & ~restore;
        rs_req = restore & ~save;
        sv_rej = sv_req & wim[cwp_m1];
        rs_rej = rs_req & wim[cwp_p1];
        cwp_nx = (sv_req & ~sv_rej) ? cwp_m1 : (rs_req & ~rs_rej) ? cwp_p1 : cwp;
        wr_ok  = rc_we & (rc_addr != 5'd0) & ~sv_rej & ~rs_rej;
        pa     = (ra_addr == 5'd0) ? 32'd0 : regs[phys(ra_addr, cwp)];
        pb     = (rb_addr == 5'd0) ? 32'd0 : regs[phys(rb_addr, cwp)];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= 32'd0;
            cwp     <= '0;
            wim     <= '0;
            win_ovf <= 1'b0;
            win_unf <= 1'b0;
        end else begin
            // the destination is decoded in the window being entered
            if (wr_ok) regs[phys(rc_addr, cwp_nx)] <= rc_data;
            cwp     <= cwp_nx;
            if (wim_we) wim <= wim_d;
            win_ovf <= sv_rej;
            win_unf <= rs_rej;
        end
    end
endmodule

// File: tb/tb_sparc_windowed_register_file.sv
// tb_sparc_windowed_register_file: random and directed stimulus scored against a per-window register model
module tb_sparc_windowed_register_file;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n, rc_we, save, restore, wim_we;
    logic [4:0]  ra_addr, rb_addr, rc_addr;
    logic [31:0] rc_data, pa, pb;
    logic [3:0]  wim_d, wim;
    logic [1:0]  cwp;
    logic        win_ovf, win_unf;

    sparc_windowed_register_file #(.NWINDOWS(N)) dut (
        .clk(clk), .rst_n(rst_n), .ra_addr(ra_addr), .rb_addr(rb_addr), .pa(pa), .pb(pb),
        .rc_addr(rc_addr), .rc_data(rc_data), .rc_we(rc_we), .save(save), .restore(restore),
        .wim_we(wim_we), .wim_d(wim_d), .cwp(cwp), .wim(wim), .win_ovf(win_ovf), .win_unf(win_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pa, pb;
        logic [1:0]  cwp;
        logic [3:0]  wim;
        logic        ovf, unf;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   passes = 0;

    // model: globals, per-window locals and outs; ins of w are the outs of w+1
    logic [31:0] g [8];
    logic [31:0] outs [N][8];
    logic [31:0] locs [N][8];
    int          mcwp;
    logic [3:0]  mwim;
    logic        mo, mu;

    function automatic logic [31:0] mread(input int r);
        if (r == 0) return 32'd0;
        if (r < 8) return g[r];
        if (r < 16) return outs[mcwp][r-8];
        if (r < 24) return locs[mcwp][r-16];
        return outs[(mcwp+1)%N][r-24];
    endfunction

    task automatic mwrite(input int r, input int w, input logic [31:0] d);
        if (r == 0) return;
        if (r < 8) g[r] = d;
        else if (r < 16) outs[w][r-8] = d;
        else if (r < 24) locs[w][r-16] = d;
        else outs[(w+1)%N][r-24] = d;
    endtask

    task automatic mreset();
        for (int i = 0; i < 8; i++) begin
            g[i] = 0;
            for (int w = 0; w < N; w++) begin
                outs[w][i] = 0;
                locs[w][i] = 0;
            end
        end
        mcwp = 0; mwim = 0; mo = 0; mu = 0;
    endtask

    task automatic mstep();
        int   nw;
        logic srej, rrej;
        if (!rst_n) begin
            mreset();
            return;
        end
        nw   = mcwp;
        srej = save && !restore && mwim[(mcwp+N-1)%N];
        rrej = restore && !save && mwim[(mcwp+1)%N];
        if (save && !restore && !srej) nw = (mcwp+N-1)%N;
        if (restore && !save && !rrej) nw = (mcwp+1)%N;
        if (rc_we && !srej && !rrej) mwrite(int'(rc_addr), nw, rc_data);
        mcwp = nw;
        if (wim_we) mwim = wim_d;
        mo = srej;
        mu = rrej;
    endtask

    task automatic op(input logic rn, sv, rs, we, input logic [4:0] rc, input logic [31:0] d,
                      input logic [4:0] ra, rb, input logic ww, input logic [3:0] wd);
        exp_t x;
        rst_n = rn; save = sv; restore = rs; rc_we = we; rc_addr = rc; rc_data = d;
        ra_addr = ra; rb_addr = rb; wim_we = ww; wim_d = wd;
        x.pa  = mread(int'(ra));
        x.pb  = mread(int'(rb));
        x.cwp = 2'(mcwp);
        x.wim = mwim;
        x.ovf = mo;
        x.unf = mu;
        q.push_back(x);
        @(posedge clk);
        mstep();
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passes++;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("pa", pa, e.pa);
            cmp("pb", pb, e.pb);
            cmp("cwp", 32'(cwp), 32'(e.cwp));
            cmp("wim", 32'(wim), 32'(e.wim));
            cmp("win_ovf", 32'(win_ovf), 32'(e.ovf));
            cmp("win_unf", 32'(win_unf), 32'(e.unf));
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; save = 0; restore = 0; rc_we = 1; rc_addr = 5; rc_data = 32'h1;
        ra_addr = 5; rb_addr = 20; wim_we = 0; wim_d = 0;
        @(posedge clk);
        mreset();
        #1;
        // reset held with a pending write
        op(0, 0, 0, 1, 5, 32'hCAFE, 5, 20, 1, 4'hF);
        op(0, 1, 0, 1, 20, 32'hCAFE, 5, 20, 0, 0);
        op(1, 0, 0, 0, 0, 0, 5, 20, 0, 0);
        // r0 discard and no bypass
        op(1, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0);
        op(1, 0, 0, 1, 17, 32'hA5A5A5A5, 17, 0, 0, 0);
        op(1, 0, 0, 0, 0, 0, 17, 0, 0, 0);
        // window overlap across SAVE
        op(1, 0, 0, 1, 9, 32'h12345678, 9, 0, 0, 0);
        op(1, 0, 0, 1, 3, 32'h0000BEEF, 9, 3, 0, 0);
        op(1, 1, 0, 0, 0, 0, 9, 3, 0, 0);
        op(1, 0, 0, 0, 0, 0, 25, 3, 0, 0);
        op(1, 0, 0, 0, 0, 0, 17, 9, 0, 0);
        op(1, 0, 1, 0, 0, 0, 17, 25, 0, 0);
        // SAVE with write lands in the new window
        op(1, 1, 0, 1, 16, 32'h11, 16, 0, 0, 0);
        op(1, 0, 0, 0, 0, 0, 16, 24, 0, 0);
        op(1, 0, 1, 0, 0, 0, 16, 0, 0, 0);
        op(1, 0, 0, 0, 0, 0, 16, 8, 0, 0);
        // overflow suppresses the write
        op(1, 0, 0, 0, 0, 0, 8, 0, 1, 4'b1000);
        op(1, 1, 0, 1, 8, 32'hFF, 8, 0, 0, 0);
        op(1, 0, 0, 0, 0, 0, 8, 0, 0, 0);
        op(1, 0, 0, 0, 0, 0, 8, 0, 0, 0);
        // underflow, then wrap 3 -> 0
        op(1, 0, 0, 0, 0, 0, 8, 0, 1, 4'b0010);
        op(1, 0, 1, 1, 10, 32'h77, 10, 0, 0, 0);
        op(1, 0, 0, 0, 0, 0, 10, 0, 0, 0);
        op(1, 0, 0, 0, 0, 0, 10, 0, 1, 4'b0000);
        op(1, 1, 0, 0, 0, 0, 10, 0, 0, 0);
        op(1, 0, 1, 0, 0, 0, 24, 16, 0, 0);
        op(1, 0, 0, 0, 0, 0, 24, 16, 0, 0);
        // save and restore together are ignored
        op(1, 1, 1, 1, 12, 32'h55, 12, 0, 0, 0);
        op(1, 0, 0, 0, 0, 0, 12, 0, 0, 0);
        // mid-sequence reset
        op(1, 1, 0, 1, 20, 32'h99, 20, 12, 1, 4'b0101);
        op(0, 1, 0, 1, 20, 32'h98, 20, 12, 1, 4'b1111);
        op(1, 0, 0, 0, 0, 0, 20, 12, 0, 0);
        op(1, 0, 0, 0, 0, 0, 3, 17, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            op($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 1) == 0, 5'($urandom), $urandom,
               5'($urandom), 5'($urandom), $urandom_range(0, 15) == 0,
               4'($urandom) & 4'($urandom));
        end
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
